piso_tx: RTL

Parallel-in serial-out transmitter. Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on ser_o, with a framing strobe.
It is the transmit end of the team's serial bit-stream link and pairs with the SIPO receiver register.
Back-to-back words stream with no idle gap.

---
 rtl/piso_pkg.sv | 13 +
 rtl/piso_bit_cnt.sv | 39 +++
 rtl/piso_tx.sv | 111 +++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for piso_tx: clear-to-zero, increment, registered terminal count.
module piso_bit_cnt
    import piso_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic          tc_q;

    assign cnt_nxt = cnt_q + 1'b1;

    // tc is computed from the next count so it is a clean flop output
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else if (clr_i) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
        end else if (inc_i) begin
            cnt_q <= cnt_nxt;
            tc_q  <= (cnt_nxt == LAST);
        end
    end

    assign tc_o = tc_q;

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready intake and framing strobes.
//   state | meaning
//   IDLE  | line quiet, ready for a word
//   SHIFT | word on the line, one bit per cycle; ready only during the last bit
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    output logic             ser_o,
    output logic             frame_o,
    output logic             last_o
);

    state_e           state_q;
    state_e           state_d;
    logic [WIDTH-1:0] sh_q;
    logic             ser_q;
    logic             frame_q;
    logic             tc;
    logic             accept;
    logic             cnt_clr;
    logic             cnt_inc;

    // tc is only ever high during the final bit of a word in SHIFT
    assign ready_o = (state_q == IDLE) || tc;
    assign accept  = valid_i && ready_o;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_clr = 1'b1;
                end
            end
            SHIFT: begin
                if (tc) begin
                    cnt_clr = 1'b1;
                    state_d = accept ? SHIFT : IDLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The first bit goes straight to ser_q at capture; sh_q holds the remainder.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sh_q    <= '0;
            ser_q   <= 1'b0;
            frame_q <= 1'b0;
        end else if (accept) begin
            frame_q <= 1'b1;
            if (LSB_FIRST) begin
                ser_q <= data_i[0];
                sh_q  <= data_i >> 1;
            end else begin
                ser_q <= data_i[WIDTH-1];
                sh_q  <= data_i << 1;
            end
        end else if (state_q == SHIFT && !tc) begin
            frame_q <= 1'b1;
            if (LSB_FIRST) begin
                ser_q <= sh_q[0];
                sh_q  <= sh_q >> 1;
            end else begin
                ser_q <= sh_q[WIDTH-1];
                sh_q  <= sh_q << 1;
            end
        end else begin
            sh_q    <= '0;
            ser_q   <= 1'b0;
            frame_q <= 1'b0;
        end
    end

    piso_bit_cnt #(
        .WIDTH (WIDTH)
    ) u_bit_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (cnt_clr),
        .inc_i   (cnt_inc),
        .tc_o    (tc)
    );

    assign ser_o   = ser_q;
    assign frame_o = frame_q;
    assign last_o  = tc;

endmodule
